// File: rtl/dbg_cmd_initiator.sv
// rtl/dbg_cmd_initiator.sv - CPU word request to debug-bus command/response initiator
// Optional sequential-address cache: define DBG_CMD_ADDR_CACHE_EN.
module dbg_cmd_initiator #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err,
   output logic        cmd_stb,
   output logic [33:0] cmd_word,
   input  logic        cmd_busy,
   input  logic        rsp_stb,
   input  logic [33:0] rsp_word
);

   typedef enum logic [2:0] {
      S_IDLE, S_SEND_ADDR, S_WAIT_ADDR, S_SEND_OP, S_WAIT_OP, S_SEND_RST, S_FINISH
   } state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [15:0] cnt_q, cnt_d;
   logic        cache_hit;
   logic        timed_out;

   assign timed_out = ({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT);

`ifdef DBG_CMD_ADDR_CACHE_EN
   logic [31:0] shadow_addr_q;
   logic        cache_valid_q;

   // Every path into FINISH carries its outcome in err_q, so the cache is updated on leaving FINISH.
   always_ff @(posedge clk) begin
      if (!reset) begin
         shadow_addr_q <= 32'd0;
         cache_valid_q <= 1'b0;
      end else if (state_q == S_FINISH) begin
         if (err_q) begin
            cache_valid_q <= 1'b0;
         end else begin
            cache_valid_q <= 1'b1;
            shadow_addr_q <= addr_q + 32'd4;
         end
      end
   end

   assign cache_hit = cache_valid_q && (req_addr == shadow_addr_q);
`else
   assign cache_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               if (req_addr[1:0] != 2'b00) begin
                  err_d   = 1'b1;
                  state_d = S_FINISH;
               end else if (cache_hit) begin
                  state_d = S_SEND_OP;
               end else begin
                  state_d = S_SEND_ADDR;
               end
            end
         end
         S_SEND_ADDR: begin
            if (!cmd_busy) begin
               cnt_d   = 16'd0;
               state_d = S_WAIT_ADDR;
            end
         end
         S_WAIT_ADDR: begin
            if (rsp_stb) begin
               if (rsp_word[33:32] == 2'b10) begin
                  state_d = S_SEND_OP;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_FINISH;
               end
            end else if (timed_out) begin
               state_d = S_SEND_RST;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_SEND_OP: begin
            if (!cmd_busy) begin
               cnt_d   = 16'd0;
               state_d = S_WAIT_OP;
            end
         end
         S_WAIT_OP: begin
            if (rsp_stb) begin
               state_d = S_FINISH;
               if (rsp_word[33:32] == {1'b0, !we_q}) begin
                  err_d = 1'b0;
                  if (!we_q) rdata_d = rsp_word[31:0];
               end else begin
                  err_d = 1'b1;
               end
            end else if (timed_out) begin
               state_d = S_SEND_RST;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_SEND_RST: begin
            if (!cmd_busy) begin
               err_d   = 1'b1;
               state_d = S_FINISH;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_stb  = 1'b0;
      cmd_word = 34'd0;
      case (state_q)
         S_SEND_ADDR: begin
            cmd_stb  = 1'b1;
            cmd_word = {2'b10, addr_q[31:2], 2'b00};
         end
         S_SEND_OP: begin
            cmd_stb  = 1'b1;
            cmd_word = we_q ? {2'b01, wdata_q} : 34'd0;
         end
         S_SEND_RST: begin
            cmd_stb  = 1'b1;
            cmd_word = {2'b11, 32'd0};
         end
         default: ;
      endcase
   end

   assign req_ready = (state_q == S_IDLE) && reset;
   assign done      = (state_q == S_FINISH);
   assign rdata     = rdata_q;
   assign err       = err_q;

endmodule

// File: tb/tb_dbg_cmd_initiator.sv
// tb/tb_dbg_cmd_initiator.sv - scoreboard bench for dbg_cmd_initiator with a scripted bus responder
module tb_dbg_cmd_initiator;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        req_ready, done, err, cmd_stb;
   logic [31:0] rdata;
   logic [33:0] cmd_word;
   logic        cmd_busy = 1'b0;
   logic        rsp_stb = 1'b0;
   logic [33:0] rsp_word = 34'd0;

   dbg_cmd_initiator #(.TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .done(done), .rdata(rdata), .err(err),
      .cmd_stb(cmd_stb), .cmd_word(cmd_word), .cmd_busy(cmd_busy),
      .rsp_stb(rsp_stb), .rsp_word(rsp_word)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
   } exp_t;

   exp_t        done_q[$];
   logic [33:0] exp_cmd_q[$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          acc_cyc = 0;

   logic [1:0]  addr_rsp_type = 2'b10;
   logic [1:0]  op_rsp_type = 2'b00;
   logic [31:0] rsp_data = 32'd0;
   bit          addr_rsp_en = 1;
   bit          op_rsp_en = 1;
   int          busy_cfg = 0;
   bit          inject_rsp = 0;
   logic [33:0] inject_word = 34'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Bus responder: applies busy stalls, checks each accepted command, answers one cycle later.
   initial begin : bus
      bit          pend = 0;
      logic [33:0] pend_word = 34'd0;
      bit          in_cmd = 0;
      int          busy_left = 0;
      logic [33:0] exp_w;
      forever begin
         @(negedge clk);
         rsp_stb = 1'b0;
         if (inject_rsp) begin
            rsp_stb    = 1'b1;
            rsp_word   = inject_word;
            inject_rsp = 0;
         end else if (pend) begin
            rsp_stb  = 1'b1;
            rsp_word = pend_word;
            pend     = 0;
         end
         if (cmd_stb) begin
            if (!in_cmd) begin
               in_cmd    = 1;
               busy_left = busy_cfg;
            end
            if (busy_left > 0) begin
               cmd_busy = 1'b1;
               busy_left--;
               if (exp_cmd_q.size() > 0) chk("cmd_stable", cmd_word, exp_cmd_q[0]);
            end else begin
               cmd_busy = 1'b0;
               in_cmd   = 0;
               if (exp_cmd_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL cmd_unexpected: got %h expected none", cmd_word);
               end else begin
                  exp_w = exp_cmd_q.pop_front();
                  chk("cmd_word", cmd_word, exp_w);
               end
               case (cmd_word[33:32])
                  2'b10: if (addr_rsp_en) begin pend = 1; pend_word = {addr_rsp_type, 32'd0}; end
                  2'b00, 2'b01: if (op_rsp_en) begin pend = 1; pend_word = {op_rsp_type, rsp_data}; end
                  default: ;
               endcase
            end
         end else begin
            cmd_busy = 1'b0;
            in_cmd   = 0;
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && done) begin
            if (done_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL done_unexpected: got done=1 expected no done");
            end else begin
               e = done_q.pop_front();
               chk("err", err, e.err);
               chk("rdata", rdata, e.rdata);
               if (e.lat != 0) chk("latency", cyc - acc_cyc, e.lat);
            end
         end
      end
   end

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic e_err, input logic [31:0] e_rdata, input int lat, input bit wait_done);
      int n;
      exp_t e;
      if (wait_done) begin
         e.err = e_err; e.rdata = e_rdata; e.lat = lat;
         done_q.push_back(e);
      end
      @(negedge clk);
      req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk("req_ready_wait", 1'b0, 1'b1);
      acc_cyc = cyc;
      @(negedge clk);
      req_valid = 1'b0;
      if (wait_done) begin
         n = 0;
         while (done_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
         if (n >= 200) chk("done_wait", 1'b0, 1'b1);
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_err", err, 1'b0);
      chk("rst_cmd_stb", cmd_stb, 1'b0);
      chk("rst_cmd_word", cmd_word, 34'd0);
      reset = 1'b1;

      exp_cmd_q.push_back(34'h2_0000_1000);
      exp_cmd_q.push_back(34'h1_DEAD_BEEF);
      do_req(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 32'd0, 5, 1);

      busy_cfg = 3; op_rsp_type = 2'b01; rsp_data = 32'h1234_5678;
      exp_cmd_q.push_back(34'h2_0000_0040);
      exp_cmd_q.push_back(34'h0_0000_0000);
      do_req(1'b0, 32'h0000_0040, 32'd0, 1'b0, 32'h1234_5678, 0, 1);
      busy_cfg = 0;

      do_req(1'b0, 32'h0000_0042, 32'd0, 1'b1, 32'h1234_5678, 1, 1);

      addr_rsp_en = 0;
      exp_cmd_q.push_back(34'h2_0000_0300);
      exp_cmd_q.push_back(34'h3_0000_0000);
      do_req(1'b0, 32'h0000_0300, 32'd0, 1'b1, 32'h1234_5678, 7, 1);
      addr_rsp_en = 1;

      addr_rsp_type = 2'b11;
      exp_cmd_q.push_back(34'h2_0000_0300);
      do_req(1'b0, 32'h0000_0300, 32'd0, 1'b1, 32'h1234_5678, 0, 1);
      addr_rsp_type = 2'b10;

      op_rsp_type = 2'b00; rsp_data = 32'h5555_5555;
      exp_cmd_q.push_back(34'h2_0000_0080);
      exp_cmd_q.push_back(34'h0_0000_0000);
      do_req(1'b0, 32'h0000_0080, 32'd0, 1'b1, 32'h1234_5678, 0, 1);

      op_rsp_type = 2'b01; rsp_data = 32'h1111_1111;
      exp_cmd_q.push_back(34'h2_0000_0100);
      exp_cmd_q.push_back(34'h0_0000_0000);
      do_req(1'b0, 32'h0000_0100, 32'd0, 1'b0, 32'h1111_1111, 5, 1);
      rsp_data = 32'h2222_2222;
`ifdef DBG_CMD_ADDR_CACHE_EN
      exp_cmd_q.push_back(34'h0_0000_0000);
      do_req(1'b0, 32'h0000_0104, 32'd0, 1'b0, 32'h2222_2222, 3, 1);
`else
      exp_cmd_q.push_back(34'h2_0000_0104);
      exp_cmd_q.push_back(34'h0_0000_0000);
      do_req(1'b0, 32'h0000_0104, 32'd0, 1'b0, 32'h2222_2222, 5, 1);
`endif
      rsp_data = 32'h3333_3333;
      exp_cmd_q.push_back(34'h2_0000_0200);
      exp_cmd_q.push_back(34'h0_0000_0000);
      do_req(1'b0, 32'h0000_0200, 32'd0, 1'b0, 32'h3333_3333, 5, 1);

      // Abort in WAIT_OP with reset, then deliver a late read response.
      op_rsp_en = 0;
      exp_cmd_q.push_back(34'h2_0000_0500);
      exp_cmd_q.push_back(34'h0_0000_0000);
      do_req(1'b0, 32'h0000_0500, 32'd0, 1'b0, 32'd0, 0, 0);
      n = 0;
      while (exp_cmd_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk("op_cmd_wait", 1'b0, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_cmd_stb", cmd_stb, 1'b0);
      reset = 1'b1;
      inject_word = 34'h1_AAAA_AAAA;
      inject_rsp  = 1;
      repeat (6) @(negedge clk);
      chk("abort_rdata", rdata, 32'd0);
      chk("abort_cmd_stb_late", cmd_stb, 1'b0);
      chk("abort_req_ready", req_ready, 1'b1);
      op_rsp_en = 1;

      op_rsp_type = 2'b00;
      exp_cmd_q.push_back(34'h2_0000_0600);
      exp_cmd_q.push_back(34'h1_CAFE_F00D);
      do_req(1'b1, 32'h0000_0600, 32'hCAFE_F00D, 1'b0, 32'd0, 5, 1);

      repeat (3) @(negedge clk);
      chk("cmd_queue_drained", exp_cmd_q.size(), 0);
      chk("done_queue_drained", done_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
